// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch/update sequencer.
//   - state_e     : 3-bit FSM encoding, also visible on state_o for debug
//   - PC_W/INSTR_W: program-counter and instruction widths
//   - pc_wrap_add : PC increment that wraps at the 16-bit boundary
package pc_pkg;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam int TMO_W   = 8;

  localparam logic [PC_W-1:0] RESET_VEC_DEFAULT = 16'h0000;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_EXEC   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  // Sum is truncated to PC_W, so 16'hFFFF + 1 lands on 16'h0000.
  function automatic logic [PC_W-1:0] pc_wrap_add(input logic [PC_W-1:0] a,
                                                  input logic [PC_W-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bus bundle between the sequencer, pc_circuit, instruction memory and the
// execute datapath.
//   master : the sequencer (drives PC strobes, fetch request, IR, status)
//   slave  : the surrounding system (drives pc, memory response, execute status)
interface pc_sequencer_if;
  import pc_pkg::*;

  logic [PC_W-1:0]    pc;
  logic               pc_ld;
  logic [PC_W-1:0]    pc_pre;
  logic               pc_rst;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] ir;
  logic               ir_valid;
  logic               ex_done;
  logic               ex_redirect;
  logic [PC_W-1:0]    ex_target;
  logic               halt_req;
  logic               resume;
  logic [2:0]         state_o;
  logic               fault;

  modport master (
    input  pc, imem_ack, imem_rdata, ex_done, ex_redirect, ex_target,
           halt_req, resume,
    output pc_ld, pc_pre, pc_rst, imem_req, imem_addr, ir, ir_valid,
           state_o, fault
  );

  modport slave (
    output pc, imem_ack, imem_rdata, ex_done, ex_redirect, ex_target,
           halt_req, resume,
    input  pc_ld, pc_pre, pc_rst, imem_req, imem_addr, ir, ir_valid,
           state_o, fault
  );

endinterface

// File: rtl/pc_next_calc.sv
// Next-PC selection: taken branch/jump target, or sequential PC + PC_INC.
//   pc_i       : current PC
//   redirect_i : branch or jump taken
//   target_i   : redirect target
//   next_o     : selected next PC (combinational)
module pc_next_calc
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_INC = 16'd1
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            redirect_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] next_o
);

  assign next_o = redirect_i ? target_i : pc_wrap_add(pc_i, PC_INC);

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/update controller for the program counter register.
// Boots the PC to RESET_VEC, fetches each instruction into the IR, hands it
// to execute, then loads the next PC (sequential or redirected). Supports a
// halt/resume handshake and a sticky fault on fetch timeout.
//   clk, rst : clock and synchronous active-high reset
//   bus      : pc_sequencer_if master view (PC strobes, imem, execute, debug)
module pc_sequencer
  import pc_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VEC     = RESET_VEC_DEFAULT,
  parameter logic [PC_W-1:0] PC_INC        = 16'd1,
  parameter int unsigned     FETCH_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst,
  pc_sequencer_if.master bus
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = FETCH_TIMEOUT[TMO_W-1:0];

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [TMO_W-1:0]   tmo_inc;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;
  logic [PC_W-1:0]    next_q, next_d;
  logic [PC_W-1:0]    next_calc;
  logic               halt_q, halt_d;
  logic               fault_q, fault_d;

  pc_next_calc #(.PC_INC(PC_INC)) u_next (
    .pc_i       (bus.pc),
    .redirect_i (bus.ex_redirect),
    .target_i   (bus.ex_target),
    .next_o     (next_calc)
  );

  assign tmo_inc = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};

  // Next-state and register-update logic for the fetch/execute sequence.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    next_d     = next_q;
    halt_d     = halt_q;
    fault_d    = fault_q;
    case (state_q)
      ST_BOOT: begin
        tmo_d   = {TMO_W{1'b0}};
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        // Ack is checked first so an ack on the limit cycle still succeeds.
        if (bus.imem_ack) begin
          ir_d       = bus.imem_rdata;
          ir_valid_d = 1'b1;
          tmo_d      = {TMO_W{1'b0}};
          state_d    = ST_EXEC;
        end else if (tmo_inc == TMO_LIMIT) begin
          tmo_d   = tmo_inc;
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          tmo_d   = tmo_inc;
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        if (bus.halt_req) begin
          halt_d = 1'b1;
        end else begin
          halt_d = halt_q;
        end
        if (bus.ex_done) begin
          next_d  = next_calc;
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_UPDATE: begin
        if (halt_q) begin
          halt_d  = 1'b0;
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HALT: begin
        if (bus.resume) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_FAULT: begin
        fault_d = 1'b1;
        state_d = ST_FAULT;
      end
      default: begin
        // Unused encodings are treated as a fault rather than silently recovered.
        fault_d = 1'b1;
        state_d = ST_FAULT;
      end
    endcase
  end

  // State register and datapath registers; rst abandons any pending load.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      tmo_q      <= {TMO_W{1'b0}};
      ir_q       <= {INSTR_W{1'b0}};
      ir_valid_q <= 1'b0;
      next_q     <= {PC_W{1'b0}};
      halt_q     <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      next_q     <= next_d;
      halt_q     <= halt_d;
      fault_q    <= fault_d;
    end
  end

  // Strobes are masked while rst is high so pc_ld never overlaps pc_rst.
  assign bus.pc_rst    = rst;
  assign bus.pc_ld     = !rst && ((state_q == ST_BOOT) || (state_q == ST_UPDATE));
  assign bus.pc_pre    = rst                   ? {PC_W{1'b0}} :
                         (state_q == ST_BOOT)   ? RESET_VEC    :
                         (state_q == ST_UPDATE) ? next_q       : {PC_W{1'b0}};
  assign bus.imem_req  = !rst && (state_q == ST_FETCH);
  assign bus.imem_addr = bus.pc;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = ir_valid_q;
  assign bus.state_o   = state_q;
  assign bus.fault     = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_reg;
  int          total = 0;
  int          bad   = 0;

  logic [15:0] ir_exp_q[$];
  logic [15:0] pre_exp_q[$];

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VEC     (16'h0000),
    .PC_INC        (16'd1),
    .FETCH_TIMEOUT (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // pc_circuit: 16-bit PC register closing the loop with the sequencer.
  always @(posedge clk) begin
    if (bus.pc_rst) pc_reg <= 16'h0000;
    else if (bus.pc_ld) pc_reg <= bus.pc_pre;
  end
  assign bus.pc = pc_reg;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: pop expectations when the DUT loads the IR or strobes pc_ld.
  always @(negedge clk) begin
    if (bus.ir_valid) begin
      if (ir_exp_q.size() == 0) chk("ir_unexpected", 16'h0001, 16'h0000);
      else chk("ir_sb", bus.ir, ir_exp_q.pop_front());
    end
    if (bus.pc_ld) begin
      if (pre_exp_q.size() == 0) chk("pc_ld_unexpected", 16'h0001, 16'h0000);
      else chk("pc_pre_sb", bus.pc_pre, pre_exp_q.pop_front());
      chk("ld_rst_excl", {15'd0, bus.pc_rst}, 16'h0000);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0000;
    bus.ex_done = 1'b0; bus.ex_redirect = 1'b0; bus.ex_target = 16'h0000;
    bus.halt_req = 1'b0; bus.resume = 1'b0;

    // Boot
    step(); step();
    chk("rst_state", {13'd0, bus.state_o}, 16'd0);
    chk("rst_pc_rst", {15'd0, bus.pc_rst}, 16'd1);
    chk("rst_pc_ld", {15'd0, bus.pc_ld}, 16'd0);
    chk("rst_pc_pre", bus.pc_pre, 16'h0000);
    chk("rst_req", {15'd0, bus.imem_req}, 16'd0);
    chk("rst_ir", bus.ir, 16'h0000);
    chk("rst_irv", {15'd0, bus.ir_valid}, 16'd0);
    chk("rst_fault", {15'd0, bus.fault}, 16'd0);
    rst = 1'b0; pre_exp_q.push_back(16'h0000); #1;
    chk("boot_ld", {15'd0, bus.pc_ld}, 16'd1);
    chk("boot_pc_rst", {15'd0, bus.pc_rst}, 16'd0);
    step();
    chk("fetch_state", {13'd0, bus.state_o}, 16'd1);
    chk("fetch_req", {15'd0, bus.imem_req}, 16'd1);
    chk("fetch_addr", bus.imem_addr, 16'h0000);
    chk("fetch_ld", {15'd0, bus.pc_ld}, 16'd0);

    // Sequential instruction
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234; ir_exp_q.push_back(16'h1234);
    step();
    bus.imem_ack = 1'b0;
    chk("exec_state", {13'd0, bus.state_o}, 16'd2);
    chk("exec_req", {15'd0, bus.imem_req}, 16'd0);
    chk("irv_pulse", {15'd0, bus.ir_valid}, 16'd1);
    chk("ir_val", bus.ir, 16'h1234);
    step();
    chk("irv_drop", {15'd0, bus.ir_valid}, 16'd0);
    chk("exec_wait", {13'd0, bus.state_o}, 16'd2);
    bus.ex_done = 1'b1; pre_exp_q.push_back(16'h0001);
    step();
    bus.ex_done = 1'b0;
    chk("upd_state", {13'd0, bus.state_o}, 16'd3);
    chk("upd_ld", {15'd0, bus.pc_ld}, 16'd1);
    chk("upd_pre", bus.pc_pre, 16'h0001);
    chk("upd_req", {15'd0, bus.imem_req}, 16'd0);
    step();
    chk("refetch_req", {15'd0, bus.imem_req}, 16'd1);
    chk("refetch_addr", bus.imem_addr, 16'h0001);

    // ex_done outside EXEC is ignored; then branch
    bus.ex_done = 1'b1;
    step(); step();
    bus.ex_done = 1'b0;
    chk("exdone_ignored", {13'd0, bus.state_o}, 16'd1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h5678; ir_exp_q.push_back(16'h5678);
    step();
    bus.imem_ack = 1'b0;
    bus.ex_done = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 16'hABCD;
    pre_exp_q.push_back(16'hABCD);
    step();
    bus.ex_done = 1'b0; bus.ex_redirect = 1'b0;
    step();
    chk("branch_addr", bus.imem_addr, 16'hABCD);

    // Jump to FFFF, then sequential wrap to 0000
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h9999; ir_exp_q.push_back(16'h9999);
    step();
    bus.imem_ack = 1'b0;
    bus.ex_done = 1'b1; bus.ex_redirect = 1'b1; bus.ex_target = 16'hFFFF;
    pre_exp_q.push_back(16'hFFFF);
    step();
    bus.ex_done = 1'b0; bus.ex_redirect = 1'b0;
    step();
    chk("jump_ffff", bus.imem_addr, 16'hFFFF);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hAAAA; ir_exp_q.push_back(16'hAAAA);
    step();
    bus.imem_rdata = 16'hDEAD;   // ack held into EXEC must not reload IR
    step();
    bus.imem_ack = 1'b0;
    chk("ack_ignored_ir", bus.ir, 16'hAAAA);
    chk("ack_ignored_st", {13'd0, bus.state_o}, 16'd2);
    bus.ex_done = 1'b1; pre_exp_q.push_back(16'h0000);
    step();
    bus.ex_done = 1'b0;
    chk("wrap_pre", bus.pc_pre, 16'h0000);
    step();
    chk("wrap_addr", bus.imem_addr, 16'h0000);

    // Halt requested together with ex_done
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1111; ir_exp_q.push_back(16'h1111);
    step();
    bus.imem_ack = 1'b0;
    bus.ex_done = 1'b1; bus.halt_req = 1'b1; pre_exp_q.push_back(16'h0001);
    step();
    bus.ex_done = 1'b0; bus.halt_req = 1'b0;
    chk("halt_upd", {13'd0, bus.state_o}, 16'd3);
    step();
    for (int i = 0; i < 10; i++) begin
      chk("halt_state", {13'd0, bus.state_o}, 16'd4);
      chk("halt_req_lo", {15'd0, bus.imem_req}, 16'd0);
      chk("halt_ld_lo", {15'd0, bus.pc_ld}, 16'd0);
      step();
    end
    bus.resume = 1'b1;
    step();
    bus.resume = 1'b0;
    chk("resume_state", {13'd0, bus.state_o}, 16'd1);
    chk("resume_addr", bus.imem_addr, 16'h0001);

    // halt_req during FETCH alone is not latched
    bus.halt_req = 1'b1;
    step();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h2222; ir_exp_q.push_back(16'h2222);
    step();
    bus.imem_ack = 1'b0; bus.halt_req = 1'b0;
    bus.ex_done = 1'b1; pre_exp_q.push_back(16'h0002);
    step();
    bus.ex_done = 1'b0;
    step();
    chk("fetch_halt_ignored", {13'd0, bus.state_o}, 16'd1);
    chk("fetch_halt_addr", bus.imem_addr, 16'h0002);

    // Fetch timeout: 15 request cycles then FAULT
    for (int i = 0; i < 14; i++) step();
    chk("tmo_cycle15", {13'd0, bus.state_o}, 16'd1);
    chk("tmo_cycle15_req", {15'd0, bus.imem_req}, 16'd1);
    step();
    chk("fault_state", {13'd0, bus.state_o}, 16'd5);
    chk("fault_flag", {15'd0, bus.fault}, 16'd1);
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) step();
    bus.imem_ack = 1'b0;
    chk("fault_sticky", {15'd0, bus.fault}, 16'd1);
    chk("fault_terminal", {13'd0, bus.state_o}, 16'd5);
    chk("fault_req", {15'd0, bus.imem_req}, 16'd0);
    chk("fault_ld", {15'd0, bus.pc_ld}, 16'd0);
    rst = 1'b1;
    step();
    chk("fault_rst_state", {13'd0, bus.state_o}, 16'd0);
    chk("fault_rst_flag", {15'd0, bus.fault}, 16'd0);
    rst = 1'b0; pre_exp_q.push_back(16'h0000);
    step();

    // Ack on the limit cycle counts as success
    for (int i = 0; i < 14; i++) step();
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h3333; ir_exp_q.push_back(16'h3333);
    step();
    bus.imem_ack = 1'b0;
    chk("limit_ack_state", {13'd0, bus.state_o}, 16'd2);
    chk("limit_ack_fault", {15'd0, bus.fault}, 16'd0);
    step();

    // Reset in the middle of EXEC
    rst = 1'b1;
    step();
    chk("midrst_state", {13'd0, bus.state_o}, 16'd0);
    chk("midrst_ir", bus.ir, 16'h0000);
    chk("midrst_fault", {15'd0, bus.fault}, 16'd0);
    chk("midrst_ld", {15'd0, bus.pc_ld}, 16'd0);
    rst = 1'b0; pre_exp_q.push_back(16'h0000); #1;
    chk("midrst_boot_ld", {15'd0, bus.pc_ld}, 16'd1);
    chk("midrst_boot_pre", bus.pc_pre, 16'h0000);
    step();
    chk("midrst_fetch", {13'd0, bus.state_o}, 16'd1);
    chk("midrst_addr", bus.imem_addr, 16'h0000);
    step();

    chk("ir_sb_drained", 16'(ir_exp_q.size()), 16'd0);
    chk("pre_sb_drained", 16'(pre_exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
